fwd_dest_pipe: RTL and testbench
================================

FWD_DEST_PIPE -- requirements
Module: fwd_dest_pipe

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all ports are listed below, clock and reset first.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous reset, active low.
REQ-004 id_rs  in  5  rs field of the instruction in ID.
REQ-005 id_rt  in  5  rt field of the instruction in ID.
REQ-006 id_valid  in  1  ID holds a real instruction.
REQ-007 ex_dest  in  5  EX-stage destination register, taken from the 4:1 destination mux output.
REQ-008 ex_regwrite  in  1  EX instruction writes the register file.
REQ-009 ex_memread  in  1  EX instruction is a load.
REQ-010 flush  in  1  squash the instructions in ID and EX (branch/jump taken).
REQ-011 fwd_a  out  2  operand-A source for the EX operand 4:1 mux: 00 regfile, 01 MEM result, 10 WB result, 11 never driven.
REQ-012 fwd_b  out  2  operand-B source, same encoding as fwd_a.
REQ-013 load_use_stall  out  1  hold PC and IF/ID, and insert a bubble.
REQ-014 mem_dest  out  5  EX/MEM destination register.
REQ-015 wb_dest  out  5  MEM/WB destination register, used as the register-file write address.
REQ-016 wb_we  out  1  register-file write enable.
REQ-017 stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-018 ID/EX: each edge SHALL load ex_rs/ex_rt <= id_rs/id_rt; on flush or load_use_stall it SHALL load 0 instead (bubble).
REQ-019 EX/MEM: each edge SHALL load mem_dest <= ex_dest and mem_we <= ex_regwrite && (ex_dest != 0); flush SHALL clear mem_we.
REQ-020 MEM/WB: each edge SHALL load wb_dest <= mem_dest and wb_we <= mem_we; flush SHALL NOT affect this stage.
REQ-021 Latency from ex_dest to wb_dest/wb_we SHALL be exactly 2 cycles.
REQ-022 fwd_a is combinational with this priority:
- 01 if mem_we && mem_dest == ex_rs
- else 10 if wb_we && wb_dest == ex_rs
- else 00.
REQ-023 fwd_b SHALL use the same rule as fwd_a, with ex_rt in place of ex_rs.
REQ-024 Register 0 SHALL never be forwarded: when ex_rs or ex_rt is 0, the corresponding select SHALL be 00.
REQ-025 load_use_stall SHALL be ex_memread && ex_regwrite && ex_dest != 0 && id_valid && (ex_dest == id_rs || ex_dest == id_rt) && !flush.
REQ-026 When flush and a load-use hazard coincide, flush SHALL win: no stall, bubble inserted.
REQ-027 When MEM and WB both match the same source register, MEM (the youngest) SHALL win.
REQ-028 stall_cnt SHALL increment on each edge where load_use_stall = 1, saturate at 16'hFFFF, and never wrap.
REQ-029 The encoding 11 SHALL never appear on fwd_a or fwd_b.

Reset
REQ-030 While rst_n = 0, the block SHALL asynchronously clear ex_rs, ex_rt, mem_dest, mem_we, wb_dest, wb_we and stall_cnt to 0.
REQ-031 Consequently, during reset fwd_a = fwd_b = 00 and wb_we = 0; load_use_stall follows its inputs.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight destinations; the first edge after release SHALL behave as a cold start.

Structure
REQ-033 A shared CPU package SHALL hold the forwarding-select constants FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10, and the register-index width 5.
REQ-034 One sub-module, fwd_cmp, SHALL compute a single 2-bit select from (src, mem_dest, mem_we, wb_dest, wb_we) and be instantiated twice.
REQ-035 All pipeline registers SHALL live in fwd_dest_pipe.

Verification
REQ-036 Back-to-back ALU dependency: ex_dest = 8 with regwrite, next id_rs = 8 -> fwd_a = 01 one cycle later; after a further cycle with no match -> fwd_a = 10.
REQ-037 Load-use: ex_memread = 1, ex_dest = 9, id_rt = 9, id_valid = 1 -> load_use_stall = 1 and stall_cnt +1; next cycle ex_rt = 0 (bubble) and fwd_b = 00.
REQ-038 Register 0: ex_dest = 0 with regwrite and a dependent id_rs = 0 -> mem_we = 0, fwd_a = 00, load_use_stall = 0.
REQ-039 Priority: MEM and WB both hold dest 5 with their enables set and ex_rs = 5 -> fwd_a = 01.
REQ-040 Flush with a load-use hazard -> load_use_stall = 0, mem_we cleared next edge, wb_we unaffected.
REQ-041 Reset: assert rst_n = 0 mid-stream -> all registered outputs 0 immediately; stall_cnt preloaded to 16'hFFFE plus 3 stalls -> stays at FFFF.

Source files
------------

// File: rtl/fwd_dest_pipe_pkg.sv
// fwd_dest_pipe_pkg: shared CPU constants and types for operand forwarding and hazard detection
package fwd_dest_pipe_pkg;
    localparam int REG_W = 5;
    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;
    function automatic logic dest_hit(input logic we, input reg_idx_t dest, input reg_idx_t src);
        return we && (dest == src) && (src != '0);
    endfunction
endpackage

// File: rtl/fwd_cmp.sv
// fwd_cmp: picks the forwarding source for one EX operand, youngest producer first
module fwd_cmp
    import fwd_dest_pipe_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_we,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_we,
    output logic [1:0]       sel
);
    always_comb
        sel = dest_hit(mem_we, mem_dest, src) ? FWD_MEM :
              dest_hit(wb_we, wb_dest, src)   ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/fwd_dest_pipe.sv
// fwd_dest_pipe: destination-register pipeline with forwarding selects and load-use stall detection
module fwd_dest_pipe
    import fwd_dest_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_valid,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             load_use_stall,
    output logic [REG_W-1:0] mem_dest,
    output logic [REG_W-1:0] wb_dest,
    output logic             wb_we,
    output logic [15:0]      stall_cnt
);
    reg_idx_t ex_rs, ex_rt;
    logic     mem_we, bubble;
    // flush squashes the hazard outright so a dead load never stalls the pipe
    assign load_use_stall = ex_memread && ex_regwrite && (ex_dest != '0) && id_valid &&
                            ((ex_dest == id_rs) || (ex_dest == id_rt)) && !flush;
    assign bubble = flush || load_use_stall;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs     <= '0;
            ex_rt     <= '0;
            mem_dest  <= '0;
            mem_we    <= 1'b0;
            wb_dest   <= '0;
            wb_we     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            ex_rs     <= bubble ? '0 : id_rs;
            ex_rt     <= bubble ? '0 : id_rt;
            mem_dest  <= ex_dest;
            mem_we    <= ex_regwrite && (ex_dest != '0) && !flush;
            wb_dest   <= mem_dest;
            wb_we     <= mem_we;
            stall_cnt <= (load_use_stall && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
        end
    end
    fwd_cmp u_cmp_a (.src(ex_rs), .mem_dest(mem_dest), .mem_we(mem_we), .wb_dest(wb_dest), .wb_we(wb_we), .sel(fwd_a));
    fwd_cmp u_cmp_b (.src(ex_rt), .mem_dest(mem_dest), .mem_we(mem_we), .wb_dest(wb_dest), .wb_we(wb_we), .sel(fwd_b));
endmodule

// File: tb/tb_fwd_dest_pipe.sv
// tb_fwd_dest_pipe: directed stimulus checked against a producer-history model plus literal expectations
module tb_fwd_dest_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_dest = '0;
    logic id_valid = 1'b0, ex_regwrite = 1'b0, ex_memread = 1'b0, flush = 1'b0;
    logic [1:0] fwd_a, fwd_b;
    logic load_use_stall, wb_we;
    logic [4:0] mem_dest, wb_dest;
    logic [15:0] stall_cnt;
    int tests = 0;
    int errs = 0;

    fwd_dest_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_valid(id_valid),
        .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use_stall(load_use_stall), .mem_dest(mem_dest),
        .wb_dest(wb_dest), .wb_we(wb_we), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // model: pdest/pwe[0] is the producer one cycle past EX (MEM), [1] is two cycles past (WB)
    logic [4:0] pdest [2] = '{5'd0, 5'd0};
    logic       pwe   [2] = '{1'b0, 1'b0};
    logic [4:0] m_rs = '0, m_rt = '0;
    logic [15:0] m_cnt = '0;

    function automatic logic stall_m();
        return ex_memread && ex_regwrite && ex_dest != 0 && id_valid &&
               (ex_dest == id_rs || ex_dest == id_rt) && !flush;
    endfunction

    function automatic logic [1:0] sel_m(input logic [4:0] s);
        for (int i = 0; i < 2; i++)
            if (s != 0 && pwe[i] && pdest[i] == s) return (i == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdest[0] = '0; pdest[1] = '0; pwe[0] = 1'b0; pwe[1] = 1'b0;
            m_rs = '0; m_rt = '0; m_cnt = '0;
        end else begin
            logic s;
            s = stall_m();
            pdest[1] = pdest[0]; pwe[1] = pwe[0];
            pdest[0] = ex_dest;  pwe[0] = ex_regwrite && ex_dest != 0 && !flush;
            m_rs = (flush || s) ? 5'd0 : id_rs;
            m_rt = (flush || s) ? 5'd0 : id_rt;
            if (s && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model fwd_a", {30'd0, fwd_a}, {30'd0, sel_m(m_rs)});
        chk("model fwd_b", {30'd0, fwd_b}, {30'd0, sel_m(m_rt)});
        chk("model stall", {31'd0, load_use_stall}, {31'd0, stall_m()});
        chk("model mem_dest", {27'd0, mem_dest}, {27'd0, pdest[0]});
        chk("model wb_dest", {27'd0, wb_dest}, {27'd0, pdest[1]});
        chk("model wb_we", {31'd0, wb_we}, {31'd0, pwe[1]});
        chk("model stall_cnt", {16'd0, stall_cnt}, {16'd0, m_cnt});
    end

    task automatic set(input logic [4:0] rs, input logic [4:0] rt, input logic v,
                       input logic [4:0] d, input logic rw, input logic mr, input logic fl);
        id_rs = rs; id_rt = rt; id_valid = v; ex_dest = d; ex_regwrite = rw; ex_memread = mr; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset fwd_a", {30'd0, fwd_a}, 0);
        chk("reset wb_we", {31'd0, wb_we}, 0);
        chk("reset stall_cnt", {16'd0, stall_cnt}, 0);
        rst_n = 1'b1;
        // back-to-back ALU dependency: MEM forward, then WB forward
        set(8, 0, 1, 8, 1, 0, 0); tick();
        chk("alu fwd_a mem", {30'd0, fwd_a}, 1);
        chk("alu mem_dest", {27'd0, mem_dest}, 8);
        set(8, 0, 1, 3, 0, 0, 0); tick();
        chk("alu fwd_a wb", {30'd0, fwd_a}, 2);
        chk("alu wb_dest", {27'd0, wb_dest}, 8);
        chk("alu wb_we", {31'd0, wb_we}, 1);
        // load-use on rt
        set(0, 9, 1, 9, 1, 1, 0); #1;
        chk("lu stall", {31'd0, load_use_stall}, 1);
        tick();
        chk("lu stall_cnt", {16'd0, stall_cnt}, 1);
        chk("lu ex_rt bubble", {27'd0, dut.ex_rt}, 0);
        chk("lu fwd_b", {30'd0, fwd_b}, 0);
        // register 0 is never a producer
        set(0, 0, 1, 0, 1, 1, 0); #1;
        chk("r0 stall", {31'd0, load_use_stall}, 0);
        tick();
        chk("r0 mem_we", {31'd0, dut.mem_we}, 0);
        chk("r0 fwd_a", {30'd0, fwd_a}, 0);
        // MEM beats WB on the same register
        set(5, 5, 1, 5, 1, 0, 0); tick();
        set(5, 5, 1, 5, 1, 0, 0); tick();
        chk("prio fwd_a", {30'd0, fwd_a}, 1);
        chk("prio fwd_b", {30'd0, fwd_b}, 1);
        chk("prio wb_we", {31'd0, wb_we}, 1);
        // flush overrides a load-use hazard
        set(0, 7, 1, 7, 1, 1, 1); #1;
        chk("flush stall", {31'd0, load_use_stall}, 0);
        tick();
        chk("flush mem_we", {31'd0, dut.mem_we}, 0);
        chk("flush wb_we", {31'd0, wb_we}, 1);
        chk("flush ex_rt", {27'd0, dut.ex_rt}, 0);
        chk("flush stall_cnt", {16'd0, stall_cnt}, 1);
        // mixed vectors, checked by the model each cycle
        set(7, 12, 1, 12, 1, 0, 0); tick();
        set(12, 7, 1, 20, 1, 0, 0); tick();
        set(20, 12, 1, 20, 1, 1, 0); tick();
        set(20, 12, 0, 20, 1, 1, 0); tick();
        set(3, 20, 1, 3, 0, 1, 0); tick();
        set(31, 31, 1, 31, 1, 0, 0); tick();
        set(31, 1, 1, 1, 1, 0, 1); tick();
        set(1, 31, 1, 0, 0, 0, 0); tick();
        // asynchronous reset mid-stream
        set(4, 4, 1, 4, 1, 0, 0); tick();
        #2 rst_n = 1'b0; #1;
        chk("arst mem_dest", {27'd0, mem_dest}, 0);
        chk("arst wb_we", {31'd0, wb_we}, 0);
        chk("arst wb_dest", {27'd0, wb_dest}, 0);
        chk("arst stall_cnt", {16'd0, stall_cnt}, 0);
        chk("arst fwd_a", {30'd0, fwd_a}, 0);
        chk("arst fwd_b", {30'd0, fwd_b}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        set(4, 0, 1, 6, 1, 0, 0); tick();
        chk("cold fwd_a", {30'd0, fwd_a}, 0);
        chk("cold wb_we", {31'd0, wb_we}, 0);
        // stall counter saturation
        set(0, 9, 1, 9, 1, 1, 0);
        repeat (65534) tick();
        chk("sat FFFE", {16'd0, stall_cnt}, 32'hFFFE);
        repeat (3) tick();
        chk("sat FFFF", {16'd0, stall_cnt}, 32'hFFFF);
        set(0, 0, 0, 0, 0, 0, 0); tick();
        chk("sat hold", {16'd0, stall_cnt}, 32'hFFFF);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
